// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - SDRAM controller request/response bundle between arbiter and controller
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] sdram_addr;
    logic [DATA_WIDTH-1:0] sdram_data;
    logic                  sdram_we;
    logic                  sdram_req;
    logic                  sdram_ack;
    logic                  sdram_valid;
    logic [DATA_WIDTH-1:0] sdram_q;

    // Arbiter side: issues requests, receives ack/valid/read data
    modport master (
        output sdram_addr,
        output sdram_data,
        output sdram_we,
        output sdram_req,
        input  sdram_ack,
        input  sdram_valid,
        input  sdram_q
    );

    // Controller side
    modport slave (
        input  sdram_addr,
        input  sdram_data,
        input  sdram_we,
        input  sdram_req,
        output sdram_ack,
        output sdram_valid,
        output sdram_q
    );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM request arbiter for one download writer and NUM_PORTS ROM readers (SDRAM_ARB_RR_EN: round-robin reads)
module sdram_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            dl_req,
    input  logic [ADDR_WIDTH-1:0]           dl_addr,
    input  logic [DATA_WIDTH-1:0]           dl_data,
    output logic                            dl_ack,
    input  logic [NUM_PORTS-1:0]            port_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
    output logic [NUM_PORTS-1:0]            port_valid,
    output logic [DATA_WIDTH-1:0]           port_q,
    sdram_arbiter_if.master                 sdram,
    output logic                            busy
);
    localparam int OW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_VALID
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic                   dl_ack_q, dl_ack_d;
    logic [NUM_PORTS-1:0]   pv_q, pv_d;
    logic [DATA_WIDTH-1:0]  q_q, q_d;
`ifdef SDRAM_ARB_RR_EN
    logic [OW-1:0]          rr_q, rr_d;
`endif

    logic [OW-1:0]          win_idx;
    logic [OW-1:0]          cand;
    logic                   win_found;
    logic [ADDR_WIDTH-1:0]  win_addr;

    // Pick the read winner among requesting ports (download priority is handled in the FSM)
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef SDRAM_ARB_RR_EN
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = OW'((int'(rr_q) + k) % NUM_PORTS);
            if (!win_found && port_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`else
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = OW'(i);
            if (port_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    assign win_addr = port_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    // Next-state and next-output logic; transaction fields only change at grant time
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        data_d   = data_q;
        owner_d  = owner_q;
        dl_ack_d = 1'b0;
        pv_d     = '0;
        q_d      = q_q;
`ifdef SDRAM_ARB_RR_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (dl_req) begin
                    addr_d  = dl_addr;
                    data_d  = dl_data;
                    we_d    = 1'b1;
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end else if (win_found) begin
                    addr_d  = win_addr;
                    owner_d = win_idx;
                    we_d    = 1'b0;
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
`ifdef SDRAM_ARB_RR_EN
                    rr_d    = win_idx;
`endif
                end else begin
                    req_d = 1'b0;
                end
            end
            WAIT_ACK: begin
                if (sdram.sdram_ack) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        dl_ack_d = 1'b1;
                        state_d  = IDLE;
                    end else if (sdram.sdram_valid) begin
                        q_d           = sdram.sdram_q;
                        pv_d[owner_q] = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        state_d = WAIT_VALID;
                    end
                end
            end
            WAIT_VALID: begin
                if (sdram.sdram_valid) begin
                    q_d           = sdram.sdram_q;
                    pv_d[owner_q] = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            owner_q  <= '0;
            dl_ack_q <= 1'b0;
            pv_q     <= '0;
            q_q      <= '0;
`ifdef SDRAM_ARB_RR_EN
            rr_q     <= OW'(NUM_PORTS - 1);
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            owner_q  <= owner_d;
            dl_ack_q <= dl_ack_d;
            pv_q     <= pv_d;
            q_q      <= q_d;
`ifdef SDRAM_ARB_RR_EN
            rr_q     <= rr_d;
`endif
        end
    end

    assign sdram.sdram_req  = req_q;
    assign sdram.sdram_we   = we_q;
    assign sdram.sdram_addr = addr_q;
    assign sdram.sdram_data = data_q;
    assign dl_ack           = dl_ack_q;
    assign port_valid       = pv_q;
    assign port_q           = q_q;
    assign busy             = (state_q != IDLE);
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller request port between one download writer and `NUM_PORTS` ROM readers (CPU program, sound, tile and sprite ROM fetchers). It sits between the game core's ROM fetch units and the `sdram` controller, and drives the controller's `addr`/`data`/`we`/`req` inputs. It routes each completed read back to the requester that issued it. Exactly one transaction is outstanding at a time.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of read requesters (2–8).
- `ADDR_WIDTH`, 23: SDRAM word address width.
- `DATA_WIDTH`, 32: SDRAM data width.

Ports:
- `clk`  in  1  system clock (96 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `dl_req`  in  1  download write request; level, held until `dl_ack`.
- `dl_addr`  in  ADDR_WIDTH  download write address.
- `dl_data`  in  DATA_WIDTH  download write data.
- `dl_ack`  out  1  one-cycle pulse when the write has been accepted by the controller.
- `port_req`  in  NUM_PORTS  per-port read request; level, held with address until `port_valid`.
- `port_addr`  in  NUM_PORTS*ADDR_WIDTH  packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `port_valid`  out  NUM_PORTS  one-hot, one-cycle pulse: read data for port i is on `port_q`.
- `port_q`  out  DATA_WIDTH  read data, held until the next read completes.
- `sdram_addr`  out  ADDR_WIDTH  address to the controller.
- `sdram_data`  out  DATA_WIDTH  write data to the controller.
- `sdram_we`  out  1  write enable to the controller.
- `sdram_req`  out  1  request to the controller.
- `sdram_ack`  in  1  controller accepted the request (one-cycle pulse).
- `sdram_valid`  in  1  controller read data valid (one-cycle pulse).
- `sdram_q`  in  DATA_WIDTH  controller read data.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT_ACK, WAIT_VALID.
- IDLE, `dl_req`=1: latch `dl_addr`/`dl_data`, set `sdram_we`=1 and `sdram_req`=1, then go to WAIT_ACK. The download port has absolute priority over all read ports.
- IDLE, `dl_req`=0 and any `port_req`=1: select a winner by the arbitration policy (see Configuration). Latch the winner's address and index, set `sdram_we`=0 and `sdram_req`=1, then go to WAIT_ACK.
- IDLE, no request: all outputs hold, and `sdram_req`=0.
- WAIT_ACK, `sdram_ack`=1:
  - Drop `sdram_req`.
  - Write: pulse `dl_ack` and return to IDLE.
  - Read with `sdram_valid` also high in the same cycle: complete immediately, as described for WAIT_VALID.
  - Read otherwise: go to WAIT_VALID.
- WAIT_VALID, `sdram_valid`=1: register `port_q`<=`sdram_q`, pulse `port_valid[owner]`, and return to IDLE.
- Address, data and `we` are latched at grant time. Changes on requester inputs after the grant do not affect the transaction in flight.
- A requester that drops `port_req` before its valid still receives the `port_valid` pulse. The transaction is never cancelled.
- The owner index is `$clog2(NUM_PORTS)` bits wide. Only the owner's `port_valid` bit ever pulses.

## Timing
- Reset values: `sdram_req`=0, `sdram_we`=0, `sdram_addr`=0, `sdram_data`=0, `port_valid`=0, `port_q`=0, `dl_ack`=0, `busy`=0. State is IDLE and the round-robin pointer is at NUM_PORTS-1.
- Grant latency: a request sampled in IDLE at edge N gives `sdram_req`=1 from edge N+1.
- `sdram_req` stays high through the `sdram_ack` cycle and is low from the following edge.
- `dl_ack` and `port_valid` are registered. They are high for exactly the one cycle after the edge that sampled `sdram_ack` (write) or `sdram_valid` (read).
- Back-to-back: the state is IDLE in the cycle that `port_valid`/`dl_ack` is high. A pending request in that cycle is granted at the next edge.
- Minimum read turnaround is therefore controller latency plus 2 cycles.
- Reset asserted mid-transaction: all outputs are forced to their reset values immediately, asynchronously. The controller shares this reset and also aborts.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round-robin among read ports.
  - The search starts at (last granted + 1) mod NUM_PORTS.
  - The pointer updates only on a read grant.
- `SDRAM_ARB_RR_EN` undefined: fixed priority, lowest port index wins.
- Download priority is unaffected in both modes.

## Test plan
- Reset released, `port_req`=0001, addr 0x000100, controller acks at +2 and valid at +5 with q=0xDEADBEEF -> `sdram_req` is high for 3 cycles; `port_valid`=0001 for exactly one cycle with `port_q`=0xDEADBEEF; `busy` is low the cycle after.
- `dl_req`=1 (addr 0x7FFFFF, data 0x12345678) and `port_req`=1111 asserted together -> write granted first with `sdram_we`=1; one `dl_ack` pulse; no `port_valid` until after `dl_ack`.
- `port_req`=1111 held continuously with `SDRAM_ARB_RR_EN` defined -> grant order 0,1,2,3,0. Without the macro -> port 0 is granted every time.
- `sdram_ack` and `sdram_valid` high in the same cycle on a read -> one `port_valid` pulse; state returns to IDLE; no extra SDRAM request issued.
- Port 2 drops `port_req` after its grant, and `port_addr` changes -> `sdram_addr` stays at the latched value; `port_valid[2]` still pulses.
- `reset_n` low while in WAIT_VALID -> `sdram_req`, `port_valid`, `busy` = 0 immediately. After release, a new request completes normally.
